// File: rtl/reduce_gate_pkg.sv
// reduce_gate_pkg
//   Shared constants and helpers for the pipelined multi-lane reduction gate.
//   - MODE_* : 2-bit operation codes carried alongside each sample.
//   - calc_stages(n_in, fanin) : smallest S with fanin**S >= n_in (tree depth).
//   - identity(mode) : neutral padding value for a mode (1 for AND/NAND, 0 otherwise).
package reduce_gate_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_AND  = 2'b00;
    localparam mode_t MODE_OR   = 2'b01;
    localparam mode_t MODE_XOR  = 2'b10;
    localparam mode_t MODE_NAND = 2'b11;

    // Integer ceil-log used as a constant expression for the tree depth.
    function automatic int calc_stages(input int n_in, input int fanin);
        int s;
        int p;
        s = 0;
        p = 1;
        while (p < n_in) begin
            p = p * fanin;
            s = s + 1;
        end
        return s;
    endfunction

    // Padding leaves must be neutral for the node operation of the mode.
    function automatic logic identity(input mode_t m);
        return (m == MODE_AND) || (m == MODE_NAND);
    endfunction

endpackage

// File: rtl/reduce_node.sv
// reduce_node
//   One FANIN-input reduction node followed by its pipeline register.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset (clears dout)
//     ce         : register update enable
//     op         : operation code; AND and NAND both reduce with AND
//     inv        : invert the reduced value (used only at the last tree level)
//     din        : FANIN node inputs
//     dout       : registered node result
module reduce_node
    import reduce_gate_pkg::*;
#(
    parameter int FANIN = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [1:0]       op,
    input  logic             inv,
    input  logic [FANIN-1:0] din,
    output logic             dout
);

    logic dout_next;

    always_comb begin
        dout_next = &din;
        case (op)
            MODE_OR:  dout_next = |din;
            MODE_XOR: dout_next = ^din;
            default:  dout_next = &din;
        endcase
        dout_next = dout_next ^ inv;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= 1'b0;
        end else if (ce) begin
            dout <= dout_next;
        end
    end

endmodule

// File: rtl/reduce_gate_pipe.sv
// reduce_gate_pipe
//   Pipelined multi-lane reduction gate. Each lane of N_IN bits is reduced by a
//   FANIN-ary registered tree of STAGES levels; the mode and valid bit travel
//   down a parallel shift register so every result carries its own mode.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     ce         : pipeline advance enable (0 freezes all state)
//     in_valid   : sample qualifier, captured only while ce=1
//     mode       : 00 AND, 01 OR, 10 XOR, 11 NAND
//     in_data    : lane k at [k*N_IN +: N_IN]
//     out_valid  : out_data/out_mode qualified
//     out_mode   : mode that produced out_data
//     out_data   : bit k = reduction of lane k
module reduce_gate_pipe
    import reduce_gate_pkg::*;
#(
    parameter int N_IN  = 8,
    parameter int LANES = 4,
    parameter int FANIN = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic [1:0]            mode,
    input  logic [LANES*N_IN-1:0] in_data,
    output logic                  out_valid,
    output logic [1:0]            out_mode,
    output logic [LANES-1:0]      out_data
);

    localparam int STAGES = calc_stages(N_IN, FANIN);
    localparam int LEAVES = FANIN ** STAGES;

    // valid/mode shift register; entry i is aligned with tree level i outputs
    logic [STAGES-1:0] valid_reg;
    logic [1:0]        mode_reg [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
            for (int i = 0; i < STAGES; i++) begin
                mode_reg[i] <= MODE_AND;
            end
        end else if (ce) begin
            valid_reg[0] <= in_valid;
            mode_reg[0]  <= mode;
            for (int i = 1; i < STAGES; i++) begin
                valid_reg[i] <= valid_reg[i-1];
                mode_reg[i]  <= mode_reg[i-1];
            end
        end
    end

    // Operation seen by each tree level: level 0 works on the incoming sample,
    // later levels on the mode registered with the data they consume.
    logic [1:0] op_at [STAGES];
    logic       last_inv;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_op
            if (gi == 0) begin : g_head
                assign op_at[gi] = mode;
            end else begin : g_tail
                assign op_at[gi] = mode_reg[gi-1];
            end
        end
    endgenerate

    assign last_inv = (op_at[STAGES-1] == MODE_NAND);

    genvar gk, gl, gn;
    generate
        for (gk = 0; gk < LANES; gk++) begin : g_lane
            logic [LEAVES-1:0] leaves;

            if (LEAVES > N_IN) begin : g_pad
                assign leaves = {{(LEAVES-N_IN){identity(mode)}}, in_data[gk*N_IN +: N_IN]};
            end else begin : g_nopad
                assign leaves = in_data[gk*N_IN +: N_IN];
            end

            for (gl = 0; gl < STAGES; gl++) begin : g_lvl
                localparam int  NODES   = FANIN ** (STAGES - 1 - gl);
                localparam bit  IS_LAST = (gl == STAGES - 1);
                logic [NODES*FANIN-1:0] din;
                logic [NODES-1:0]       dout;

                if (gl == 0) begin : g_first
                    assign din = leaves;
                end else begin : g_rest
                    assign din = g_lvl[gl-1].dout;
                end

                for (gn = 0; gn < NODES; gn++) begin : g_node
                    reduce_node #(
                        .FANIN(FANIN)
                    ) u_node (
                        .clk  (clk),
                        .rst_n(rst_n),
                        .ce   (ce),
                        .op   (op_at[gl]),
                        .inv  (last_inv & IS_LAST),
                        .din  (din[gn*FANIN +: FANIN]),
                        .dout (dout[gn])
                    );
                end
            end

            assign out_data[gk] = g_lvl[STAGES-1].dout[0];
        end
    endgenerate

    assign out_valid = valid_reg[STAGES-1];
    assign out_mode  = mode_reg[STAGES-1];

endmodule

// File: tb/tb_reduce_gate_pipe.sv
// tb_reduce_gate_pipe
//   Directed scenarios on the default configuration plus a randomized sweep
//   over three configurations (8/3, 9/3, 5/2) against a popcount-based model.
module tb_reduce_gate_pipe;
    import reduce_gate_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        ce;
    logic        in_valid;
    logic [1:0]  mode;
    logic [31:0] d8;
    logic [35:0] d9;
    logic [19:0] d5;

    logic       ov8, ov9, ov5;
    logic [1:0] om8, om9, om5;
    logic [3:0] od8, od9, od5;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic       v;
        logic [1:0] m;
        logic [3:0] r;
    } exp_t;

    exp_t q8[$];
    exp_t q9[$];
    exp_t q5[$];

    reduce_gate_pipe #(.N_IN(8), .LANES(4), .FANIN(3)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .mode(mode),
        .in_data(d8), .out_valid(ov8), .out_mode(om8), .out_data(od8)
    );

    reduce_gate_pipe #(.N_IN(9), .LANES(4), .FANIN(3)) dut_n9 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .mode(mode),
        .in_data(d9), .out_valid(ov9), .out_mode(om9), .out_data(od9)
    );

    reduce_gate_pipe #(.N_IN(5), .LANES(4), .FANIN(2)) dut_n5 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .mode(mode),
        .in_data(d5), .out_valid(ov5), .out_mode(om5), .out_data(od5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    // Reference: count ones per lane and decide from the count.
    function automatic logic [3:0] ref_red(input logic [35:0] d, input logic [1:0] m, input int n);
        logic [3:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            int ones;
            ones = 0;
            for (int i = 0; i < n; i++) begin
                ones += int'(d[k*n + i]);
            end
            case (m)
                MODE_AND:  r[k] = (ones == n);
                MODE_OR:   r[k] = (ones != 0);
                MODE_XOR:  r[k] = ones[0];
                default:   r[k] = (ones != n);
            endcase
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [31:0] d);
        in_valid = v;
        mode     = m;
        d8       = d;
        d9       = {4'($urandom), 32'($urandom)};
        d5       = 20'($urandom);
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [1:0] m, input logic [3:0] d);
        check({tag, "_valid"}, 32'(ov8), 32'(v));
        check({tag, "_mode"},  32'(om8), 32'(m));
        check({tag, "_data"},  32'(od8), 32'(d));
        $display("txn %s: out_valid=%0b out_mode=%0d out_data=%04b", tag, ov8, om8, od8);
    endtask

    task automatic cmp_out(input string tag, input bit full, input exp_t e,
                           input logic v, input logic [1:0] m, input logic [3:0] d);
        logic want_v;
        want_v = full ? e.v : 1'b0;
        check({tag, "_valid"}, 32'(v), 32'(want_v));
        if (want_v) begin
            check({tag, "_mode"}, 32'(m), 32'(e.m));
            check({tag, "_data"}, 32'(d), 32'(e.r));
        end
    endtask

    initial begin
        exp_t e;
        exp_t blank;
        blank = '0;

        rst_n = 1'b1;
        ce = 1'b1;
        drive(1'b0, MODE_AND, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        expect_out("reset", 1'b0, 2'b00, 4'b0000);
        step();
        step();
        #3 rst_n = 1'b1;
        step();

        // AND, all lanes set
        drive(1'b1, MODE_AND, 32'hFFFF_FFFF);
        step();
        check("and_early_valid", 32'(ov8), 32'd0);
        drive(1'b0, MODE_AND, 32'h0);
        step();
        expect_out("and_all", 1'b1, MODE_AND, 4'b1111);
        step();
        check("and_after_valid", 32'(ov8), 32'd0);

        // OR, single bit in lane 2: padding must not leak a 1
        drive(1'b1, MODE_OR, 32'h0080_0000);
        step();
        drive(1'b0, MODE_OR, 32'h0);
        step();
        expect_out("or_lane2", 1'b1, MODE_OR, 4'b0100);

        // Per-cycle mode change
        drive(1'b1, MODE_XOR, 32'hFFB0_0100);
        step();
        drive(1'b1, MODE_NAND, 32'hFFB0_0100);
        step();
        expect_out("xor", 1'b1, MODE_XOR, 4'b0110);
        drive(1'b0, MODE_OR, 32'h0);
        step();
        expect_out("nand", 1'b1, MODE_NAND, 4'b0111);
        step();
        expect_out("flush", 1'b0, MODE_OR, 4'b0000);

        // Stall with one sample in flight
        drive(1'b1, MODE_AND, 32'hFFFF_FFFF);
        step();
        expect_out("pre_stall", 1'b0, MODE_OR, 4'b0000);
        ce = 1'b0;
        drive(1'b1, MODE_XOR, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("stall_hold", 1'b0, MODE_OR, 4'b0000);
        end
        ce = 1'b1;
        drive(1'b0, MODE_OR, 32'h0);
        step();
        expect_out("stall_release", 1'b1, MODE_AND, 4'b1111);
        step();
        check("stall_drop_1", 32'(ov8), 32'd0);
        step();
        check("stall_drop_2", 32'(ov8), 32'd0);

        // Asynchronous reset with two samples in flight
        drive(1'b1, MODE_AND, 32'hFFFF_FFFF);
        step();
        drive(1'b1, MODE_OR, 32'hFFFF_FFFF);
        step();
        #3 rst_n = 1'b0;
        #1;
        expect_out("async_rst", 1'b0, 2'b00, 4'b0000);
        step();
        drive(1'b0, MODE_AND, 32'h0);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_quiet", 32'(ov8), 32'd0);
        end
        drive(1'b1, MODE_XOR, 32'hFFB0_0100);
        step();
        check("post_rst_early", 32'(ov8), 32'd0);
        drive(1'b0, MODE_AND, 32'h0);
        step();
        expect_out("post_rst_new", 1'b1, MODE_XOR, 4'b0110);

        // Randomized sweep across three configurations
        rst_n = 1'b0;
        step();
        #3 rst_n = 1'b1;
        q8.delete();
        q9.delete();
        q5.delete();
        for (int s = 0; s < 1000; s++) begin
            ce = ($urandom_range(0, 3) != 0);
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
            if (ce) begin
                e.v = in_valid; e.m = mode; e.r = ref_red({4'b0, d8}, mode, 8);
                q8.push_back(e);
                if (q8.size() > 2) void'(q8.pop_front());
                e.r = ref_red(d9, mode, 9);
                q9.push_back(e);
                if (q9.size() > 2) void'(q9.pop_front());
                e.r = ref_red({16'b0, d5}, mode, 5);
                q5.push_back(e);
                if (q5.size() > 3) void'(q5.pop_front());
            end
            step();
            cmp_out("sweep_n8", q8.size() == 2, (q8.size() == 2) ? q8[0] : blank, ov8, om8, od8);
            cmp_out("sweep_n9", q9.size() == 2, (q9.size() == 2) ? q9[0] : blank, ov9, om9, od9);
            cmp_out("sweep_n5", q5.size() == 3, (q5.size() == 3) ? q5[0] : blank, ov5, om5, od5);
            if (ov8) begin
                $display("txn sweep %0d: mode=%0d data=%04b", s, om8, od8);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reduce_gate_pipe.md
# reduce_gate_pipe

Parametrised, pipelined multi-lane reduction gate. It generalises the fixed 3-input delayed AND to N inputs per lane, several independent lanes, a run-time selectable operation (AND/OR/XOR/NAND) and a registered tree of FANIN-input nodes. It sits between wide status/flag buses and the control logic that needs one qualified bit per lane. It replaces chains of hand-instantiated delayed gates with a block that has deterministic cycle latency.

## Interface
- N_IN, 8: inputs reduced per lane; ≥2.
- LANES, 4: independent reduction lanes; ≥1.
- FANIN, 3: inputs per tree node; ≥2.
- STAGES (localparam): smallest S with FANIN^S ≥ N_IN. For the defaults this is 2 (8→3→1).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ce  in  1  pipeline advance enable; 0 freezes every stage.
- in_valid  in  1  in_data/mode qualified this cycle.
- mode  in  2  00 AND, 01 OR, 10 XOR, 11 NAND.
- in_data  in  LANES*N_IN  lane k occupies bits [k*N_IN +: N_IN].
- out_valid  out  1  out_data/out_mode qualified.
- out_mode  out  2  mode that produced out_data.
- out_data  out  LANES  bit k = reduction of lane k.

## Operation
- Each lane is reduced by a FANIN-ary tree with STAGES register levels. The tree is padded to FANIN^STAGES leaves.
- Padding leaves carry the identity of the captured mode: 1 for AND/NAND, 0 for OR/XOR. Padding must never change the result.
- Internal nodes apply AND for AND/NAND, OR for OR, and XOR for XOR.
- NAND inverts only at the final stage.
- mode and in_valid are captured with in_data and travel down the pipeline alongside it. Every result therefore uses its own mode, even if mode changes every cycle.
- All lanes share one valid/mode pipeline and always complete together.
- Data is registered whatever in_valid is. out_data is only meaningful while out_valid=1.
- There is no backpressure output. The consumer controls the pipeline through ce.

## Timing
- Reset (rst_n=0, asynchronous, takes effect immediately without a clock edge):
  - out_valid=0, out_mode=00, out_data=0.
  - All stage registers and valid bits cleared.
- Latency: with ce held 1, a sample accepted at edge t appears on the outputs after edge t+STAGES-1. That is STAGES cycles from the input edge: 2 cycles for the defaults.
- Throughput: one sample per cycle while ce=1.
- ce=0:
  - No register changes, including the valid pipeline.
  - Outputs hold their values.
  - in_valid presented during ce=0 is ignored (dropped).
- Reset mid-flight: every in-flight sample is discarded. The first out_valid after rst_n rises is STAGES cycles after the first accepted in_valid.
- Simultaneous rst_n=0 and ce=1: reset wins.
- Width rule: the output is exactly 1 bit per lane. No carry or overflow.

## Structure
- Package reduce_gate_pkg:
  - mode constants MODE_AND/OR/XOR/NAND.
  - function calc_stages(N_IN, FANIN), a constant-expression integer ceil-log.
  - function identity(mode).
- Sub-module reduce_node:
  - one FANIN-input combinational reduction (AND/OR/XOR chosen by a 2-bit op), followed by a ce-gated, rst_n-cleared register.
  - The top level builds the LANES × tree array of these nodes with generate loops, plus the valid/mode shift register.

## Test plan
(All scenarios use the defaults N_IN=8, LANES=4, FANIN=3. Latency is 2 cycles.)
- AND, all lanes 0xFF, in_valid=1 one cycle → 2 cycles later out_valid=1, out_data=4'b1111, out_mode=00. Next cycle out_valid=0.
- OR, only lane 2 bit 7 set (in_data=32'h0080_0000) → out_data=4'b0100. This checks that padding leaves do not leak a 1.
- Per-cycle mode change on consecutive cycles, input data 32'hFF_B0_01_00:
  - XOR → out_data=4'b0110 (lane3 0xFF parity 0, lane2 0xB0 parity 1, lane1 0x01 parity 1, lane0 0x00 parity 0).
  - NAND with the same data → 4'b0111.
  - Results appear on consecutive cycles, each tagged with its own out_mode.
- Stall: issue AND 0xFFFFFFFF, drop ce for 3 cycles after one cycle in flight → outputs hold unchanged during the stall. The result appears 1 cycle after ce returns. The in_valid asserted during the stall never appears on out_valid.
- Async reset mid-flight: two samples in flight, pull rst_n low between clock edges → out_valid/out_data read 0 before the next edge. After release, no spurious out_valid occurs, and a new sample completes in 2 cycles.
- Parameter sweep: N_IN=9/FANIN=3 (STAGES=2) and N_IN=5/FANIN=2 (STAGES=3), random data against a reference model, 1000 samples → zero mismatches, latency equal to STAGES.
